dot_product_seq_ctrl: RTL
=========================

Name: dot_product_seq_ctrl

Overview:
Parametrised sequencing controller for the dot-product accelerator; replaces the fixed IDLE/COMPUTE/DONE controller.
- Owns the element counter internally. Length is programmable per job.
- Accepts operand beats over a valid/ready handshake.
- Waits out the MAC pipeline latency, then holds the result under a valid/ready handshake.
- Adds abort, accumulate-across-jobs mode and length error reporting. Sits between the AXI-Lite register block and the MAC datapath.

Parameters:
MAX_LEN, 1024, largest legal vector length in elements.
CNT_W, $clog2(MAX_LEN+1), width of length/count fields (derived; not overridden).
MAC_LAT, 2, pipeline depth of the MAC datapath in cycles (0 legal).

Ports:
clk  in  1  clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  job request, sampled in IDLE only
len  in  CNT_W  vector length, sampled with accepted start
accumulate  in  1  1 = keep accumulator contents (no clr_acc), sampled with start
abort  in  1  cancel current job
in_valid  in  1  operand pair valid
in_ready  out  1  controller accepts operand pair
mac_en  out  1  MAC enable, = in_valid && in_ready
clr_acc  out  1  clear accumulator, one cycle
res_valid  out  1  result in accumulator is final
res_ready  in  1  consumer takes result
done  out  1  one-cycle pulse on result handshake
aborted  out  1  one-cycle pulse when abort takes effect
err_len  out  1  one-cycle pulse on illegal length
busy  out  1  state != IDLE
count  out  CNT_W  beats accepted in current/last job

Behaviour:
- Reset (reset_n low, async): state IDLE, count 0, remaining 0, drain counter 0. All outputs 0.
- States: IDLE, COMPUTE, DRAIN, RESULT.
- Decoded from state: in_ready = COMPUTE, res_valid = RESULT, busy = !IDLE.
- Combinational pulses: mac_en, done, clr_acc, err_len, aborted.
- IDLE:
  - start && 1<=len<=MAX_LEN: go to COMPUTE. Load remaining=len, count=0. clr_acc=1 that same cycle unless accumulate=1.
  - start && (len==0 || len>MAX_LEN): err_len=1 that cycle, stay IDLE, count unchanged.
  - abort in IDLE: no effect.
- COMPUTE:
  - A beat is in_valid && in_ready. Each beat: mac_en=1, remaining-1, count+1.
  - Beat with remaining==1: go to DRAIN with drain counter=MAC_LAT-1; go straight to RESULT if MAC_LAT==0.
  - No beat: hold all state. Gaps in in_valid are legal and unbounded.
- DRAIN: in_ready=0. Decrement drain counter; at 0 go to RESULT. Lasts exactly MAC_LAT cycles.
- Latency: last beat in cycle t, res_valid first high in cycle t+1+MAC_LAT.
- RESULT:
  - res_valid held until res_valid && res_ready. In that cycle done=1; next state IDLE.
  - res_ready already high on entry gives RESULT for one cycle.
- abort in COMPUTE/DRAIN/RESULT:
  - Next state IDLE, aborted=1 that cycle.
  - Abort beats a simultaneous beat: mac_en=0, in_ready still 1, beat not counted.
  - Abort in RESULT with res_ready=1: done=0.
  - count keeps its value from before the abort cycle.
- start outside IDLE is ignored. start and a completing handshake in the same cycle: start ignored; a new job needs start in IDLE.
- len==MAX_LEN: counter reaches MAX_LEN with no overflow. count saturates by construction (never exceeds len).
- Reset mid-job: immediate return to reset values; no done/aborted pulse.

Decomposition:
- Package dp_ctrl_pkg:
  - state_t enum (IDLE, COMPUTE, DRAIN, RESULT), 2 bits.
  - localparam defaults for MAX_LEN and MAC_LAT.
  - Shared with the register block and scoreboard.
- One sub-module, dp_len_counter: loadable down-counter with a terminal flag (remaining==1), parametrised by CNT_W. It is instantiated for remaining. Drain counter stays inline.

Test Plan:
- len=4, accumulate=0, in_valid continuous, res_ready=1, MAC_LAT=2:
  - clr_acc at start cycle, 4 mac_en pulses.
  - res_valid 3 cycles after the 4th beat; done pulse; count=4; busy falls next cycle.
- len=5, in_valid toggling 1/0, res_ready held 0 for 6 cycles:
  - exactly 5 mac_en.
  - res_valid stable high 6 cycles, done only when res_ready rises.
- Job 1 len=3, then job 2 len=2 with accumulate=1: no clr_acc on job 2; count=2 after job 2.
- start with len=0, then len=MAX_LEN+1: err_len pulse each, busy stays 0; then len=MAX_LEN completes with count=1024.
- Abort in the same cycle as the 2nd beat of len=4:
  - mac_en=0 that cycle, aborted=1, count=1, no res_valid.
  - Then a fresh start len=1 completes normally.
- Drop reset_n mid-DRAIN: all outputs 0 asynchronously, state IDLE. Repeat the len=1 job with MAC_LAT=0: res_valid the cycle after the beat.

Source files
------------

// File: rtl/dp_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dp_ctrl_pkg
// Description : Shared types and defaults for the dot-product sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package dp_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DRAIN   = 2'd2,
        RESULT  = 2'd3
    } state_t;

    localparam int c_max_len_default = 1024;
    localparam int c_mac_lat_default = 2;

endpackage
`default_nettype wire

// File: rtl/dp_len_counter.sv
`default_nettype none
// ============================================================================
// Module      : dp_len_counter
// Description : Loadable down-counter flagging the final element of a job.
// Revision    : 1.0 - initial release
// ============================================================================
module dp_len_counter #(
    parameter int CNT_W = 11
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_last
);

    logic [CNT_W-1:0] r_remaining;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_remaining <= '0;
        end else if (i_load) begin
            r_remaining <= i_load_val;
        end else if (i_dec && (r_remaining != '0)) begin
            r_remaining <= r_remaining - CNT_W'(1);
        end
    end

    assign o_last = (r_remaining == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/dot_product_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dot_product_seq_ctrl
// Description : Job sequencer for the dot-product MAC: operand intake, pipeline
//               drain, result handshake, abort and length checking.
// Revision    : 1.0 - initial release
// ============================================================================
module dot_product_seq_ctrl
    import dp_ctrl_pkg::*;
#(
    parameter  int MAX_LEN = c_max_len_default,
    parameter  int MAC_LAT = c_mac_lat_default,
    localparam int CNT_W   = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             accumulate,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             mac_en,
    output logic             clr_acc,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             done,
    output logic             aborted,
    output logic             err_len,
    output logic             busy,
    output logic [CNT_W-1:0] count
);

    localparam int               c_drn_w    = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
    localparam logic [c_drn_w-1:0] c_drn_init = c_drn_w'((MAC_LAT > 0) ? MAC_LAT - 1 : 0);
    localparam logic [CNT_W-1:0] c_max_len  = CNT_W'(MAX_LEN);

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_count;
    logic [c_drn_w-1:0] r_drain;
    logic               w_beat;
    logic               w_last;
    logic               w_load;
    logic               w_len_ok;

    assign in_ready  = (r_state == COMPUTE);
    assign res_valid = (r_state == RESULT);
    assign busy      = (r_state != IDLE);
    assign count     = r_count;

    assign w_len_ok  = (len != '0) && (len <= c_max_len);
    // Abort wins over a coincident beat so the cancelled job never sees it.
    assign w_beat    = in_valid && in_ready && !abort;
    assign mac_en    = w_beat;

    dp_len_counter #(
        .CNT_W (CNT_W)
    ) u_len_counter (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_load     (w_load),
        .i_load_val (len),
        .i_dec      (w_beat),
        .o_last     (w_last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Pulses are gated by reset_n so every output reads 0 while reset is held.
    always_comb begin
        w_next  = r_state;
        w_load  = 1'b0;
        clr_acc = 1'b0;
        err_len = 1'b0;
        done    = 1'b0;
        aborted = 1'b0;
        if (reset_n) begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (w_len_ok) begin
                            w_next  = COMPUTE;
                            w_load  = 1'b1;
                            clr_acc = !accumulate;
                        end else begin
                            err_len = 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    if (abort) begin
                        w_next  = IDLE;
                        aborted = 1'b1;
                    end else if (w_beat && w_last) begin
                        w_next = (MAC_LAT == 0) ? RESULT : DRAIN;
                    end
                end
                DRAIN: begin
                    if (abort) begin
                        w_next  = IDLE;
                        aborted = 1'b1;
                    end else if (r_drain == '0) begin
                        w_next = RESULT;
                    end
                end
                RESULT: begin
                    if (abort) begin
                        w_next  = IDLE;
                        aborted = 1'b1;
                    end else if (res_ready) begin
                        w_next = IDLE;
                        done   = 1'b1;
                    end
                end
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_drain <= '0;
        end else if ((r_state == COMPUTE) && w_beat && w_last) begin
            r_drain <= c_drn_init;
        end else if ((r_state == DRAIN) && (r_drain != '0)) begin
            r_drain <= r_drain - c_drn_w'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (w_load) begin
            r_count <= '0;
        end else if (w_beat) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire
